// File: rtl/conv_bank_arbiter.sv
// conv_bank_arbiter
// Round-robin owner selection for the convolution-engine write bus shared by
// 8 requesters. One requester owns the bus for at most BURST_LEN beats, and
// every pair of grants is separated by at least one idle cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req[7:0]   per-requester level request
//   beat       one transfer completed by the current owner (ignored when idle)
//   gnt_idx    current/last owner index, drives bank-select decoder select
//   gnt_en     grant active, drives bank-select decoder enable
//   gnt_onehot registered one-hot grant back to the requesters
//   burst_last the next beat completes the burst
//   busy       arbitration or grant in progress
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; wait for any request
// ARB   | one cycle: pick first request after ptr, register the grant
// GRANT | owner holds the bus until burst completes or it withdraws
module conv_bank_arbiter #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       beat,
  output logic [2:0] gnt_idx,
  output logic       gnt_en,
  output logic [7:0] gnt_onehot,
  output logic       burst_last,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_d;
  logic             en_d;
  logic [7:0]       oh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel;
  logic [2:0]       cand;
  logic             sel_vld;

  // Rotating scan starting just after the last owner, so that owner ends up
  // with the lowest priority in the next arbitration.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!sel_vld && req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = gnt_idx;
    en_d    = gnt_en;
    oh_d    = gnt_onehot;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (sel_vld) begin
          idx_d   = sel;
          en_d    = 1'b1;
          oh_d    = 8'b1 << sel;
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (beat) cnt_d = cnt_q + CNT_W'(1);
        // A beat arriving together with the withdrawal is still counted, but
        // the exit clears the count anyway.
        if ((beat && (cnt_q == LAST_CNT)) || !req[gnt_idx]) begin
          ptr_d   = gnt_idx;
          en_d    = 1'b0;
          oh_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd7;
      gnt_idx    <= '0;
      gnt_en     <= 1'b0;
      gnt_onehot <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx    <= idx_d;
      gnt_en     <= en_d;
      gnt_onehot <= oh_d;
      cnt_q      <= cnt_d;
    end
  end

  assign burst_last = gnt_en && (cnt_q == LAST_CNT);
  assign busy       = (state_q != IDLE);

endmodule
